// File: rtl/snake_pkg.sv
// Shared headings, FSM states and the cell-coordinate type for the snake engine.
package snake_pkg;

    localparam int unsigned CoordW = 8;

    localparam logic [3:0] DIR_R = 4'b0001;
    localparam logic [3:0] DIR_D = 4'b0010;
    localparam logic [3:0] DIR_L = 4'b0100;
    localparam logic [3:0] DIR_U = 4'b1000;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        MOVE,
        WR_TAIL,
        WR_HEAD,
        DEAD
    } state_e;

    typedef struct packed {
        logic [CoordW-1:0] row;
        logic [CoordW-1:0] col;
    } coord_t;

    // Headings are arranged so that a two-bit rotation gives the opposite one.
    function automatic logic [3:0] reverse(input logic [3:0] dir);
        return {dir[1:0], dir[3:2]};
    endfunction

endpackage

// File: rtl/snake_body_fifo.sv
// Circular buffer of body cells; head is the newest entry, tail the oldest.
module snake_body_fifo
    import snake_pkg::*;
#(
    parameter int unsigned MAX_LEN  = 64,
    parameter int unsigned INIT_LEN = 3,
    parameter int unsigned INIT_ROW = 8,
    localparam int unsigned PW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1,
    localparam int unsigned LW = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          init,
    input  logic          push_head,
    input  logic          pop_tail,
    input  coord_t        head_in,
    output coord_t        head,
    output coord_t        tail,
    output logic [LW-1:0] count
);

    coord_t        mem_q [MAX_LEN];
    logic [PW-1:0] hp_q, tp_q, hp_nxt, tp_nxt;
    logic [LW-1:0] count_q;

    function automatic coord_t init_cell(input int unsigned i);
        coord_t c;
        c.row = CoordW'(INIT_ROW);
        c.col = (i < INIT_LEN) ? CoordW'(i) : '0;
        return c;
    endfunction

    assign hp_nxt = (hp_q == PW'(MAX_LEN - 1)) ? '0 : hp_q + 1'b1;
    assign tp_nxt = (tp_q == PW'(MAX_LEN - 1)) ? '0 : tp_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < MAX_LEN; i++) mem_q[i] <= init_cell(i);
            hp_q    <= PW'(INIT_LEN - 1);
            tp_q    <= '0;
            count_q <= LW'(INIT_LEN);
        end else if (init) begin
            for (int unsigned i = 0; i < MAX_LEN; i++) mem_q[i] <= init_cell(i);
            hp_q    <= PW'(INIT_LEN - 1);
            tp_q    <= '0;
            count_q <= LW'(INIT_LEN);
        end else begin
            // At full capacity a push overwrites the slot the tail is leaving.
            if (push_head) begin
                mem_q[hp_nxt] <= head_in;
                hp_q          <= hp_nxt;
            end
            if (pop_tail) tp_q <= tp_nxt;
            if (push_head && !pop_tail) begin
                count_q <= count_q + 1'b1;
            end else if (!push_head && pop_tail) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign head  = mem_q[hp_q];
    assign tail  = mem_q[tp_q];
    assign count = count_q;

endmodule

// File: rtl/snake_engine.sv
// Snake body engine: steps the head on each tick, tracks occupancy and emits
// incremental framebuffer writes (clear old tail, light new head).
module snake_engine
    import snake_pkg::*;
#(
    parameter int unsigned ROWS     = 16,
    parameter int unsigned COLS     = 24,
    parameter int unsigned MAX_LEN  = 64,
    parameter int unsigned INIT_LEN = 3,
    parameter int unsigned WRAP     = 1,
    localparam int unsigned RW = $clog2(ROWS),
    localparam int unsigned CW = $clog2(COLS),
    localparam int unsigned LW = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tick,
    input  logic [3:0]    dir_req,
    input  logic          grow,
    input  logic          restart,
    output logic          pix_we,
    output logic [RW-1:0] pix_row,
    output logic [CW-1:0] pix_col,
    output logic          pix_val,
    output logic [RW-1:0] head_row,
    output logic [CW-1:0] head_col,
    output logic [LW-1:0] length,
    output logic          busy,
    output logic          step_done,
    output logic          game_over
);

    localparam int unsigned CELLS    = ROWS * COLS;
    localparam int unsigned IW       = $clog2(CELLS);
    localparam int unsigned INIT_ROW = ROWS / 2;

    function automatic logic [CELLS-1:0] init_map();
        logic [CELLS-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < INIT_LEN; i++) m[INIT_ROW * COLS + i] = 1'b1;
        return m;
    endfunction

    localparam logic [CELLS-1:0] INIT_MAP = init_map();

    state_e           state_q, state_d;
    logic [3:0]       heading_q, heading_d, last_dir_q, last_dir_d;
    logic             grow_pend_q, grow_pend_d;
    logic [CELLS-1:0] bitmap_q, bitmap_d;
    logic [LW-1:0]    init_cnt_q, init_cnt_d;
    logic             pix_we_d, pix_val_d, step_done_d;
    logic [RW-1:0]    pix_row_d, nr, hr;
    logic [CW-1:0]    pix_col_d, nc, hc;
    logic [IW-1:0]    next_idx, tail_idx;
    logic             at_edge, growing, vacating, dies, commit, dir_ok;
    coord_t           cur_head, cur_tail, new_head;
    logic [LW-1:0]    count;
    logic             unused_coord;

    snake_body_fifo #(
        .MAX_LEN (MAX_LEN),
        .INIT_LEN(INIT_LEN),
        .INIT_ROW(INIT_ROW)
    ) u_body (
        .clk      (clk),
        .rst_n    (rst_n),
        .init     (restart),
        .push_head(commit),
        .pop_tail (commit && !growing),
        .head_in  (new_head),
        .head     (cur_head),
        .tail     (cur_tail),
        .count    (count)
    );

    assign hr           = cur_head.row[RW-1:0];
    assign hc           = cur_head.col[CW-1:0];
    assign unused_coord = ^{cur_head.row[CoordW-1:RW], cur_head.col[CoordW-1:CW],
                            cur_tail.row[CoordW-1:RW], cur_tail.col[CoordW-1:CW]};

    always_comb begin
        nr      = hr;
        nc      = hc;
        at_edge = 1'b0;
        unique case (heading_q)
            DIR_R: if (hc == CW'(COLS - 1)) begin nc = '0; at_edge = 1'b1; end
                   else nc = hc + 1'b1;
            DIR_D: if (hr == RW'(ROWS - 1)) begin nr = '0; at_edge = 1'b1; end
                   else nr = hr + 1'b1;
            DIR_L: if (hc == '0) begin nc = CW'(COLS - 1); at_edge = 1'b1; end
                   else nc = hc - 1'b1;
            DIR_U: if (hr == '0) begin nr = RW'(ROWS - 1); at_edge = 1'b1; end
                   else nr = hr - 1'b1;
            default: ;
        endcase
    end

    assign new_head = '{row: CoordW'(nr), col: CoordW'(nc)};
    assign next_idx = IW'(nr) * IW'(COLS) + IW'(nc);
    assign tail_idx = IW'(cur_tail.row[RW-1:0]) * IW'(COLS) + IW'(cur_tail.col[CW-1:0]);
    assign growing  = grow_pend_q && (count < LW'(MAX_LEN));
    // Without growth the tail leaves this step, so stepping onto it is legal.
    assign vacating = !growing && (nr == cur_tail.row[RW-1:0]) && (nc == cur_tail.col[CW-1:0]);
    assign dies     = (at_edge && (WRAP == 0)) || (bitmap_q[next_idx] && !vacating);
    assign commit   = (state_q == MOVE) && !dies && !restart;
    assign dir_ok   = (dir_req != 4'd0) && ((dir_req & (dir_req - 4'd1)) == 4'd0) &&
                      (dir_req != reverse(last_dir_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INIT;
            heading_q   <= DIR_R;
            last_dir_q  <= DIR_R;
            grow_pend_q <= 1'b0;
            bitmap_q    <= INIT_MAP;
            init_cnt_q  <= '0;
            pix_we      <= 1'b0;
            pix_val     <= 1'b0;
            pix_row     <= '0;
            pix_col     <= '0;
            step_done   <= 1'b0;
        end else begin
            state_q     <= state_d;
            heading_q   <= heading_d;
            last_dir_q  <= last_dir_d;
            grow_pend_q <= grow_pend_d;
            bitmap_q    <= bitmap_d;
            init_cnt_q  <= init_cnt_d;
            pix_we      <= pix_we_d;
            pix_val     <= pix_val_d;
            pix_row     <= pix_row_d;
            pix_col     <= pix_col_d;
            step_done   <= step_done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        if (restart) begin
            state_d    = INIT;
            init_cnt_d = '0;
        end else begin
            case (state_q)
                INIT:    if (init_cnt_q == LW'(INIT_LEN)) state_d = IDLE;
                         else init_cnt_d = init_cnt_q + 1'b1;
                IDLE:    if (tick) state_d = MOVE;
                MOVE:    state_d = dies ? DEAD : (growing ? WR_HEAD : WR_TAIL);
                WR_TAIL: state_d = WR_HEAD;
                WR_HEAD: state_d = IDLE;
                DEAD:    state_d = DEAD;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        heading_d   = heading_q;
        last_dir_d  = last_dir_q;
        grow_pend_d = grow_pend_q;
        bitmap_d    = bitmap_q;
        if (dir_ok) heading_d = dir_req;
        if (state_q == MOVE) grow_pend_d = 1'b0;
        if (commit) begin
            last_dir_d = heading_q;
            if (!growing) bitmap_d[tail_idx] = 1'b0;
            bitmap_d[next_idx] = 1'b1;
        end
        if (grow) grow_pend_d = 1'b1;
        if (restart) begin
            heading_d   = DIR_R;
            last_dir_d  = DIR_R;
            grow_pend_d = 1'b0;
            bitmap_d    = INIT_MAP;
        end
    end

    // Pixel outputs are registered, so each write is prepared one state early.
    always_comb begin
        pix_we_d    = 1'b0;
        pix_val_d   = 1'b0;
        pix_row_d   = '0;
        pix_col_d   = '0;
        step_done_d = 1'b0;
        if (!restart) begin
            case (state_q)
                INIT: if (init_cnt_q < LW'(INIT_LEN)) begin
                    pix_we_d  = 1'b1;
                    pix_val_d = 1'b1;
                    pix_row_d = RW'(INIT_ROW);
                    pix_col_d = CW'(init_cnt_q);
                end
                MOVE: if (!dies) begin
                    pix_we_d    = 1'b1;
                    pix_val_d   = growing;
                    pix_row_d   = growing ? nr : cur_tail.row[RW-1:0];
                    pix_col_d   = growing ? nc : cur_tail.col[CW-1:0];
                    step_done_d = growing;
                end
                WR_TAIL: begin
                    pix_we_d    = 1'b1;
                    pix_val_d   = 1'b1;
                    pix_row_d   = hr;
                    pix_col_d   = hc;
                    step_done_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign head_row  = hr;
    assign head_col  = hc;
    assign length    = count;
    assign busy      = (state_q != IDLE) && (state_q != DEAD);
    assign game_over = (state_q == DEAD);

endmodule
